// File: rtl/bus_region_decoder.sv
// Registered memory-map decoder: NUM_REGIONS base/limit windows to one-hot chip enables with per-region
// wait states on o_ready and external-owner lockout. Optional write-protect check under `WP_CHECK_EN.

module bus_region_match #(
    parameter int              ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] LIMIT  = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o
);
    assign hit_o = (addr_i >= BASE) && (addr_i <= LIMIT);
endmodule

module bus_region_decoder #(
    parameter int NUM_REGIONS = 5,
    parameter int ADDR_W      = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'hA002, 16'hA001, 16'hA000, 16'h3000, 16'h1000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'hA002, 16'hA001, 16'hA000, 16'h7FFF, 16'h2FFF},
    parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT  = {4'd0, 4'd0, 4'd0, 4'd3, 4'd0},
    parameter logic [NUM_REGIONS-1:0]        LOCK_MASK    = 5'b00010,
    parameter logic [NUM_REGIONS-1:0]        RO_MASK      = 5'b00000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_rw,
    input  logic [ADDR_W-1:0]      i_address,
    input  logic                   i_lock,
    output logic [NUM_REGIONS-1:0] o_ce,
    output logic                   o_ready,
    output logic                   o_miss,
    output logic                   o_busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [NUM_REGIONS-1:0] ce_q, ce_d;
    logic                   ready_q, ready_d;
    logic                   miss_q, miss_d;
    logic                   busy_q, busy_d;
    logic                   valid_q;
    logic                   lock_q;
    logic [3:0]             cnt_q, cnt_d;

    logic [NUM_REGIONS-1:0] win_hit;
    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] first;
    logic [3:0]             wait_sel;
    logic                   ro_block;
    logic                   start;
    logic                   lock_abort;

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        bus_region_match #(
            .ADDR_W (ADDR_W),
            .BASE   (REGION_BASE[r*ADDR_W +: ADDR_W]),
            .LIMIT  (REGION_LIMIT[r*ADDR_W +: ADDR_W])
        ) u_match (
            .addr_i (i_address),
            .hit_o  (win_hit[r])
        );
    end

    // Lowest-index match wins: isolate the least significant set bit.
    always_comb begin
        hit      = win_hit & ~(LOCK_MASK & {NUM_REGIONS{i_lock}});
        first    = hit & (~hit + NUM_REGIONS'(1));
        wait_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (first[i]) wait_sel = wait_sel | REGION_WAIT[i*4 +: 4];
        end
    end

`ifdef WP_CHECK_EN
    assign ro_block = (|(first & RO_MASK)) & ~i_rw;
`else
    wire unused_rw = i_rw;
    assign ro_block = 1'b0;
`endif

    assign start      = i_valid & ~valid_q;
    // Only a fresh lock edge aborts, and only if the owned region is the one selected.
    assign lock_abort = i_lock & ~lock_q & (|(ce_q & LOCK_MASK));

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        miss_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ce_d    = '0;
                ready_d = 1'b1;
                cnt_d   = '0;
                if (start) begin
                    if ((|first) && !ro_block) begin
                        ce_d = first;
                        if (wait_sel == 4'd0) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            state_d = ST_WAIT;
                            ready_d = 1'b0;
                            cnt_d   = wait_sel;
                        end
                    end else begin
                        miss_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (lock_abort || !i_valid) begin
                    state_d = ST_IDLE;
                    ce_d    = '0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    miss_d  = lock_abort;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_ACTIVE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACTIVE: begin
                if (lock_abort || !i_valid) begin
                    state_d = ST_IDLE;
                    ce_d    = '0;
                    ready_d = 1'b1;
                    miss_d  = lock_abort;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ce_d    = '0;
                ready_d = 1'b1;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ce_q    <= '0;
            ready_q <= 1'b1;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            ready_q <= ready_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
            valid_q <= i_valid;
            lock_q  <= i_lock;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ce    = ce_q;
    assign o_ready = ready_q;
    assign o_miss  = miss_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_bus_region_decoder.sv
// Scoreboard bench for bus_region_decoder: transaction-level reference model predicts per-cycle outputs.
module tb_bus_region_decoder;
    typedef struct packed {
        logic [4:0] ce;
        logic       rdy;
        logic       miss;
        logic       busy;
    } obs_t;
    typedef struct {
        int   due;
        obs_t o;
    } sb_t;

    localparam int BASE [5] = '{'h1000, 'h3000, 'hA000, 'hA001, 'hA002};
    localparam int LIMIT[5] = '{'h2FFF, 'h7FFF, 'hA000, 'hA001, 'hA002};
    localparam int WAITS[5] = '{0, 3, 0, 0, 0};
    localparam logic [4:0] LOCKM = 5'b00010;
`ifdef WP_CHECK_EN
    localparam logic [4:0] RO = 5'b00010;
    localparam bit WP = 1'b1;
`else
    localparam logic [4:0] RO = 5'b00000;
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_rw = 1'b1;
    logic [15:0] i_address = '0;
    logic        i_lock = 1'b0;
    logic [4:0]  o_ce;
    logic        o_ready, o_miss, o_busy;

    bus_region_decoder #(.RO_MASK(RO)) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_rw      (i_rw),
        .i_address (i_address),
        .i_lock    (i_lock),
        .o_ce      (o_ce),
        .o_ready   (o_ready),
        .o_miss    (o_miss),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    sb_t  sb[$];
    sb_t  ent;
    obs_t got;
    localparam obs_t IDLE_O = '{ce: 5'b0, rdy: 1'b1, miss: 1'b0, busy: 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            ent = sb.pop_front();
            got = {o_ce, o_ready, o_miss, o_busy};
            total++;
            if (ent.due != cyc || got !== ent.o) begin
                bad++;
                $display("FAIL outputs cyc=%0d due=%0d got ce=%b rdy=%b miss=%b busy=%b want ce=%b rdy=%b miss=%b busy=%b",
                         cyc, ent.due, got.ce, got.rdy, got.miss, got.busy,
                         ent.o.ce, ent.o.rdy, ent.o.miss, ent.o.busy);
            end
        end
    end

    task automatic drive(input bit v, input bit rw, input bit lk, input bit rst,
                         input logic [15:0] a, input obs_t e);
        @(posedge clk);
        #1;
        i_valid   = v;
        i_rw      = rw;
        i_lock    = lk;
        i_reset   = rst;
        i_address = a;
        sb.push_back(sb_t'{cyc + 1, e});
    endtask

    // Region the memory map assigns to an access, or -1 when unmapped, locked out or write-protected.
    function automatic int find_region(int a, bit lk, bit rw);
        for (int i = 0; i < 5; i++) begin
            if (a >= BASE[i] && a <= LIMIT[i] && !(LOCKM[i] && lk)) begin
                if (WP && RO[i] && !rw) return -1;
                return i;
            end
        end
        return -1;
    endfunction

    // One bus cycle: held `hold` clocks, optional lock rise at hold cycle `rise`, optional reset on the last.
    task automatic txn(input int a, input bit rw, input bit ls, input int hold,
                       input int rise, input bit rst_last, input int gap);
        int   m;
        int   w;
        bit   dead;
        bit   lk;
        bit   rst;
        obs_t e;
        m    = find_region(a, ls, rw);
        w    = (m >= 0) ? WAITS[m] : 0;
        dead = 1'b0;
        for (int j = 1; j <= hold; j++) begin
            lk  = ls | (rise != 0 && j >= rise);
            rst = rst_last && (j == hold);
            e   = IDLE_O;
            if (rst) begin
                dead = 1'b1;
            end else if (m < 0) begin
                e.miss = (j == 1);
            end else if (!dead) begin
                if (rise != 0 && j == rise && LOCKM[m]) begin
                    e.miss = 1'b1;
                    dead   = 1'b1;
                end else begin
                    e.ce   = 5'(1 << m);
                    e.rdy  = (j > w);
                    e.busy = 1'b1;
                end
            end
            drive(1'b1, rw, lk, rst, 16'(a), e);
        end
        for (int g = 0; g < gap; g++) drive(1'b0, rw, 1'b0, 1'b0, 16'(a), IDLE_O);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int picks[8] = '{'h1000, 'h2FFF, 'h3000, 'h7FFF, 'h8000, 'hA000, 'hA001, 'hA002};
        int a, hold, rise;
        bit ls;
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, IDLE_O);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, IDLE_O);

        txn('h1000, 1, 0, 4, 0, 0, 1);
        txn('h3000, 1, 0, 6, 0, 0, 1);
        txn('h3000, 1, 1, 3, 0, 0, 1);
        txn('h8000, 1, 0, 3, 0, 0, 1);
        txn('h7FFF, 1, 0, 5, 0, 0, 1);
        txn('hA000, 1, 0, 2, 0, 0, 1);
        txn('hA001, 1, 0, 2, 0, 0, 1);
        txn('hA002, 1, 0, 2, 0, 0, 1);
        txn('h3000, 1, 0, 2, 0, 0, 1);
        txn('h3000, 1, 0, 5, 3, 0, 1);
        txn('h3000, 1, 0, 7, 6, 0, 1);
        txn('h1000, 1, 0, 4, 2, 0, 1);
        txn('h3000, 1, 0, 3, 0, 1, 1);
        txn('h4000, 0, 0, 5, 0, 0, 1);
        txn('h4000, 1, 0, 5, 0, 0, 2);

        for (int n = 0; n < 250; n++) begin
            a    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16'hFFFF)) : picks[$urandom_range(0, 7)];
            ls   = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(1, 8);
            rise = (!ls && hold >= 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(2, hold)) : 0;
            txn(a, 1'($urandom_range(0, 1)), ls, hold, rise,
                (rise == 0 && $urandom_range(0, 19) == 0), $urandom_range(1, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
